// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Small instruction FIFO between fetch (PC generation + instruction memory)
//   and decode. Each fetched {instruction, PC, PC+4} triple is captured into a
//   DEPTH-entry circular buffer and the oldest entry is presented to decode.
//   A decode stall holds the head entry, full_o back-pressures the PC register,
//   and a redirect flush discards every buffered entry.
//
//   Optional feature macro: FETCH_BUF_BYPASS_EN
//     When defined, an empty buffer forwards the incoming triple to the decode
//     outputs in the same cycle. If decode is not stalled the triple is
//     consumed directly and never written into storage.
//     When undefined, there is no combinational input-to-output path.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   InstrF_i    instruction word from instruction memory
//   PCF_i       PC of InstrF_i
//   PCPlus4F_i  PCF_i + 4
//   ValidF_i    fetch triple valid this cycle (push request)
//   StallD_i    decode stalled, head entry is not consumed
//   FlushD_i    redirect, discard all entries
//   full_o      buffer holds DEPTH entries, push refused (drives PCen low)
//   InstrD_o    head instruction (NOP addi x0,x0,0 when empty)
//   PCD_o       head PC (0 when empty)
//   PCPlus4D_o  head PC+4 (0 when empty)
//   ValidD_o    head entry valid
//   count_o     number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      InstrF_i,
  input  logic [DATA_WIDTH-1:0]      PCF_i,
  input  logic [DATA_WIDTH-1:0]      PCPlus4F_i,
  input  logic                       ValidF_i,
  input  logic                       StallD_i,
  input  logic                       FlushD_i,
  output logic                       full_o,
  output logic [DATA_WIDTH-1:0]      InstrD_o,
  output logic [DATA_WIDTH-1:0]      PCD_o,
  output logic [DATA_WIDTH-1:0]      PCPlus4D_o,
  output logic                       ValidD_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic stored_valid;
  logic full;
  logic bypass_show;   // incoming triple forwarded to decode outputs this cycle
  logic bypass_take;   // forwarded triple consumed by decode, skip storage
  logic push;
  logic pop;

  assign stored_valid = (count != '0);
  // full depends on registered state only, so PCen never sees a path from StallD_i.
  assign full         = (count == CW'(DEPTH));
  assign head         = mem[rd_ptr];

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass_show = ~stored_valid & ValidF_i & ~FlushD_i;
  assign bypass_take = bypass_show & ~StallD_i;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A refused push stays refused even if a pop frees a slot this same cycle.
  assign push = ValidF_i & ~full & ~FlushD_i & ~bypass_take;
  // Only stored entries are popped; a bypassed triple never reaches storage.
  assign pop  = stored_valid & ~StallD_i & ~FlushD_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FlushD_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only visible after it has been
  // written, and the reset count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: InstrF_i, pc: PCF_i, pc_plus4: PCPlus4F_i};
  end

  // NOTE: every output gets a default first, so no latch is inferred.
  always_comb begin
    ValidD_o   = 1'b0;
    InstrD_o   = NOP_INSTR;
    PCD_o      = '0;
    PCPlus4D_o = '0;
    if (stored_valid) begin
      ValidD_o   = 1'b1;
      InstrD_o   = head.instr;
      PCD_o      = head.pc;
      PCPlus4D_o = head.pc_plus4;
    end else if (bypass_show) begin
      ValidD_o   = 1'b1;
      InstrD_o   = InstrF_i;
      PCD_o      = PCF_i;
      PCPlus4D_o = PCPlus4F_i;
    end
  end

  assign full_o  = full;
  assign count_o = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//   Self-checking bench for fetch_buffer. A queue-based reference model tracks
//   the buffered triples; a compare process checks every DUT output against it
//   on each falling edge while out of reset. Directed sequences add literal
//   expectations and an order check on the stream of consumed PCs.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] InstrF_i = '0, PCF_i = '0, PCPlus4F_i = '0;
  logic          ValidF_i = 1'b0, StallD_i = 1'b0, FlushD_i = 1'b0;
  logic          full_o, ValidD_o;
  logic [DW-1:0] InstrD_o, PCD_o, PCPlus4D_o;
  logic [CW-1:0] count_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
  } trip_t;

  trip_t         model_q[$];
  logic [DW-1:0] popped[$];
  bit            record_en = 1'b0;

  fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .InstrF_i(InstrF_i), .PCF_i(PCF_i), .PCPlus4F_i(PCPlus4F_i),
    .ValidF_i(ValidF_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
    .full_o(full_o), .InstrD_o(InstrD_o), .PCD_o(PCD_o),
    .PCPlus4D_o(PCPlus4D_o), .ValidD_o(ValidD_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
    return 32'h0050_0093 + (pc << 20);
  endfunction

`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model: a FIFO of triples with FIFO rules applied per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (FlushD_i) begin
      model_q.delete();
    end else begin
      automatic bit was_full = (model_q.size() == DEPTH);
      automatic bit taken    = BYPASS && model_q.size() == 0 && ValidF_i && !StallD_i;
      if (model_q.size() > 0 && !StallD_i) void'(model_q.pop_front());
      if (ValidF_i && !was_full && !taken)
        model_q.push_back('{instr: InstrF_i, pc: PCF_i, pc4: PCPlus4F_i});
    end
  end

  // Compare process: outputs are stable mid-cycle; check them against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic          e_valid = 1'b0;
      automatic logic [DW-1:0] e_instr = 32'h13, e_pc = '0, e_pc4 = '0;
      if (model_q.size() > 0) begin
        e_valid = 1'b1; e_instr = model_q[0].instr; e_pc = model_q[0].pc; e_pc4 = model_q[0].pc4;
      end else if (BYPASS && ValidF_i && !FlushD_i) begin
        e_valid = 1'b1; e_instr = InstrF_i; e_pc = PCF_i; e_pc4 = PCPlus4F_i;
      end
      check("model_valid", DW'(ValidD_o), DW'(e_valid));
      check("model_instr", InstrD_o, e_instr);
      check("model_pc",    PCD_o,    e_pc);
      check("model_pc4",   PCPlus4D_o, e_pc4);
      check("model_count", DW'(count_o), DW'(model_q.size()));
      check("model_full",  DW'(full_o),  DW'(model_q.size() == DEPTH));
      if (record_en && ValidD_o && !StallD_i && !FlushD_i) popped.push_back(PCD_o);
    end
  end

  // Drive one cycle of inputs just after a rising edge, then wait for the next.
  task automatic drive(input bit v, input logic [DW-1:0] pc, input bit stall, input bit flush);
    ValidF_i   = v;
    PCF_i      = pc;
    PCPlus4F_i = pc + 4;
    InstrF_i   = instr_of(pc);
    StallD_i   = stall;
    FlushD_i   = flush;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    logic [DW-1:0] next_pc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", DW'(ValidD_o), 0);
    check("rst_instr", InstrD_o, 32'h0000_0013);
    check("rst_count", DW'(count_o), 0);
    check("rst_full",  DW'(full_o), 0);
    rst_n = 1'b1;

    // Test 1: single triple
    drive(1, 32'h0, 0, 0);
`ifdef FETCH_BUF_BYPASS_EN
    #1;
    check("t1_byp_valid", DW'(ValidD_o), 1);
    check("t1_byp_instr", InstrD_o, 32'h0050_0093);
    cycle();
    check("t1_byp_count", DW'(count_o), 0);
    drive(0, 32'h0, 0, 0);
`else
    cycle();
    drive(0, 32'h0, 0, 0);
    check("t1_valid", DW'(ValidD_o), 1);
    check("t1_instr", InstrD_o, 32'h0050_0093);
    check("t1_pc",    PCD_o, 32'h0);
    check("t1_pc4",   PCPlus4D_o, 32'h4);
    check("t1_count", DW'(count_o), 1);
    cycle();
    check("t1_popped_count", DW'(count_o), 0);
    check("t1_popped_instr", InstrD_o, 32'h0000_0013);
`endif

    // Test 2: fill under stall, refused push, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(i * 4), 1, 0);
      cycle();
    end
    check("t2_count4", DW'(count_o), 4);
    check("t2_full",   DW'(full_o), 1);
    drive(1, 32'h10, 1, 0);
    cycle();
    check("t2_refused_count", DW'(count_o), 4);
    check("t2_head_pc", PCD_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 0, 0);
      check("t2_drain_pc", PCD_o, DW'(i * 4));
      cycle();
    end
    check("t2_empty_valid", DW'(ValidD_o), 0);
    check("t2_empty_instr", InstrD_o, 32'h0000_0013);

    // Test 3: full with simultaneous push attempt and pop
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(32'h40 + i * 4), 1, 0);
      cycle();
    end
    check("t3_full", DW'(full_o), 1);
    drive(1, 32'h50, 0, 0);
    cycle();
    check("t3_count3", DW'(count_o), 3);
    check("t3_head_pc", PCD_o, 32'h44);

    // Test 4: flush with a same-cycle push
    drive(1, 32'h60, 0, 1);
    cycle();
    check("t4_count0", DW'(count_o), 0);
    check("t4_valid0", DW'(ValidD_o), 0);
    drive(1, 32'h100, 1, 0);
    cycle();
    drive(0, 32'h0, 1, 0);
    check("t4_first_pc", PCD_o, 32'h100);
    check("t4_count1", DW'(count_o), 1);
    drive(0, 32'h0, 0, 0);
    cycle();

    // Test 5: wrap-around stream with random stalls
    popped.delete();
    record_en = 1'b1;
    next_pc = '0;
    guard = 0;
    while (next_pc < 32'h28 && guard < 200) begin
      automatic bit st = 1'($urandom_range(0, 1));
      automatic bit accepted = !full_o;
      drive(1, next_pc, st, 0);
      cycle();
      if (accepted) next_pc = next_pc + 4;
      guard++;
    end
    check("t5_push_bound", DW'(guard < 200), 1);
    drive(0, 32'h0, 0, 0);
    repeat (DEPTH + 2) cycle();
    record_en = 1'b0;
    check("t5_pop_total", DW'(popped.size()), 10);
    for (int i = 0; i < 10; i++) begin
      automatic logic [DW-1:0] got = (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
      check("t5_order", got, DW'(i * 4));
    end

    // Test 6: asynchronous reset mid-cycle with two entries stored
    drive(1, 32'h200, 1, 0);
    cycle();
    drive(1, 32'h204, 1, 0);
    cycle();
    drive(0, 32'h0, 1, 0);
    check("t6_count2", DW'(count_o), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", DW'(count_o), 0);
    check("t6_rst_valid", DW'(ValidD_o), 0);
    check("t6_rst_instr", InstrD_o, 32'h0000_0013);
    check("t6_rst_pc",    PCD_o, 32'h0);
    check("t6_rst_full",  DW'(full_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 32'h300, 1, 0);
    cycle();
    drive(0, 32'h0, 0, 0);
    check("t6_after_pc", PCD_o, 32'h300);
    cycle();
    check("t6_final_count", DW'(count_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction FIFO between the fetch stage (PC generation plus instruction memory) and the decode stage of the pipelined core.
- Captures each fetched {instruction, PC, PC+4} triple and presents the oldest entry to decode.
- Decouples a decode stall from PC advance; back-pressures the PC register through full_o, which drives PCen low.
- Discards all buffered entries on a branch/jump redirect flush.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and PC+4 fields.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InstrF_i  input  DATA_WIDTH  instruction word from instruction memory.
- PCF_i  input  DATA_WIDTH  PC of InstrF_i.
- PCPlus4F_i  input  DATA_WIDTH  PCF_i + 4.
- ValidF_i  input  1  fetch triple valid this cycle (push request).
- StallD_i  input  1  decode stalled; head entry is not consumed.
- FlushD_i  input  1  redirect; discard all entries.
- full_o  input-side  output  1  high when count_o == DEPTH; push is refused.
- InstrD_o  output  DATA_WIDTH  head instruction to decode.
- PCD_o  output  DATA_WIDTH  head PC.
- PCPlus4D_o  output  DATA_WIDTH  head PC+4.
- ValidD_o  output  1  head entry valid.
- count_o  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count register runs 0..DEPTH.
- push = ValidF_i & ~full_o & ~FlushD_i.
  - Push is refused when full, even if a pop occurs in the same cycle.
  - full_o is registered-state derived only, with no combinational path from StallD_i.
- pop = ValidD_o & ~StallD_i & ~FlushD_i.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop when empty: ignored; pointers and count hold.
- Flush (FlushD_i=1) at a clock edge:
  - wr_ptr, rd_ptr and count go to 0.
  - A same-cycle push is dropped.
  - Flush has priority over push and pop.
- Head outputs are driven from storage[rd_ptr] when count > 0.
- Empty outputs: ValidD_o=0, InstrD_o=32'h00000013 (NOP, addi x0,x0,0), PCD_o=0, PCPlus4D_o=0.
- Latency (macro off): a triple pushed at edge N appears on the D outputs, with ValidD_o=1, after edge N and is stable through cycle N+1.
- Decode holds its inputs while StallD_i=1; outputs do not change unless a flush occurs.
- Reset (rst_n low, asynchronous, any time including mid-stream):
  - Pointers and count go to 0 immediately.
  - ValidD_o=0, full_o=0, count_o=0, D outputs take their empty values.
  - Storage contents need not be cleared.
- On rst_n release, the first push is accepted on the next rising edge.
- No state machine beyond pointer/count; no X on outputs after reset.

Optional Feature:
- FETCH_BUF_BYPASS_EN defined: when count==0 and ValidF_i=1 and FlushD_i=0:
  - D outputs show InstrF_i/PCF_i/PCPlus4F_i combinationally, with ValidD_o=1.
  - If StallD_i=0 the triple is consumed that cycle and not written to storage (count stays 0).
  - If StallD_i=1 it is pushed normally.
- FETCH_BUF_BYPASS_EN undefined: no combinational input-to-output path; minimum latency is one cycle as above.

Test Plan:
- Reset, then push one triple (Instr=0x00500093, PC=0x0, PC+4=0x4), StallD_i=0 -> ValidD_o=1 with those values the next cycle, popped the cycle after, count_o returns 0; with bypass on, visible the same cycle and count_o stays 0.
- StallD_i=1, push PCs 0x0,0x4,0x8,0xC -> count_o=4, full_o=1; push PC 0x10 refused; release stall -> outputs PCs 0x0,0x4,0x8,0xC in order, then ValidD_o=0, InstrD_o=0x00000013.
- Full, ValidF_i=1 and StallD_i=0 in the same cycle -> pop occurs, push refused, count_o=3.
- count_o=3, FlushD_i=1 with ValidF_i=1 -> next cycle count_o=0, ValidD_o=0, pushed triple not stored; a following push of PC 0x100 is output first.
- Wrap-around: stream 10 sequential triples (PC 0x0..0x24) with random 1-cycle stalls -> every PC is output exactly once, in order, none lost or duplicated.
- Assert rst_n low mid-cycle with count_o=2 -> outputs go to reset values immediately, before the next clock edge.
